// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter in front of a shared combinational shifter
// Define SHIFT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module shift_arbiter #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] d0,
    input  logic [2:0] amt0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] d1,
    input  logic [2:0] amt1,
    output logic       gnt1,
    output logic [7:0] shf_d,
    output logic [7:0] shf_n,
    input  logic [7:0] shf_w,
    output logic [7:0] res,
    output logic       res_valid,
    output logic       res_id
);

    typedef enum logic [1:0] {IDLE, SETTLE_WAIT, CAPTURE} state_t;

    localparam logic [1:0] CNT_INIT = 2'(SETTLE - 1);

    state_t     r_state;
    logic [1:0] r_cnt;
    logic [7:0] r_shf_d;
    logic [7:0] r_shf_n;
    logic [7:0] r_res;
    logic       r_res_valid;
    logic       r_res_id;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_owner;

    logic       w_pick1;
    logic [7:0] w_d;
    logic [2:0] w_amt;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    assign w_pick1 = req1 & ~req0;
`else
    // r_last holds the requester granted most recently; on a tie the other one wins.
    logic r_last;
    assign w_pick1 = req1 & (~req0 | ~r_last);
`endif

    assign w_d   = w_pick1 ? d1   : d0;
    assign w_amt = w_pick1 ? amt1 : amt0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_shf_d     <= 8'd0;
            r_shf_n     <= 8'b0000_0001;
            r_res       <= 8'd0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_owner     <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            r_last      <= 1'b1;
`endif
        end else begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req0 | req1) begin
                        r_owner <= w_pick1;
                        r_shf_d <= w_d;
                        r_shf_n <= 8'd1 << w_amt;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
                        r_last  <= w_pick1;
`endif
                        r_cnt   <= CNT_INIT;
                        r_state <= SETTLE_WAIT;
                    end
                end
                SETTLE_WAIT: begin
                    if (r_cnt == 2'd0) r_state <= CAPTURE;
                    else               r_cnt   <= r_cnt - 2'd1;
                end
                CAPTURE: begin
                    r_res       <= shf_w;
                    r_res_id    <= r_owner;
                    r_res_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign shf_d     = r_shf_d;
    assign shf_n     = r_shf_n;
    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed self-checking bench for shift_arbiter (SETTLE=1 and SETTLE=4 instances)
module tb_shift_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic       req0 = 0, req1 = 0, gnt0, gnt1, res_valid, res_id;
    logic [7:0] d0 = 0, d1 = 0, shf_d, shf_n, shf_w, res;
    logic [2:0] amt0 = 0, amt1 = 0;

    logic       req0_b = 0, req1_b = 0, gnt0_b, gnt1_b, res_valid_b, res_id_b;
    logic [7:0] d0_b = 0, d1_b = 0, shf_d_b, shf_n_b, shf_w_b, res_b;
    logic [2:0] amt0_b = 0, amt1_b = 0;

    function automatic logic [2:0] bit_idx(input logic [7:0] n);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (n[i]) r = 3'(i);
        return r;
    endfunction

    assign shf_w   = shf_d   << bit_idx(shf_n);
    assign shf_w_b = shf_d_b << bit_idx(shf_n_b);

    shift_arbiter #(.SETTLE(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .d0(d0), .amt0(amt0), .gnt0(gnt0),
        .req1(req1), .d1(d1), .amt1(amt1), .gnt1(gnt1),
        .shf_d(shf_d), .shf_n(shf_n), .shf_w(shf_w),
        .res(res), .res_valid(res_valid), .res_id(res_id)
    );

    shift_arbiter #(.SETTLE(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req0(req0_b), .d0(d0_b), .amt0(amt0_b), .gnt0(gnt0_b),
        .req1(req1_b), .d1(d1_b), .amt1(amt1_b), .gnt1(gnt1_b),
        .shf_d(shf_d_b), .shf_n(shf_n_b), .shf_w(shf_w_b),
        .res(res_b), .res_valid(res_valid_b), .res_id(res_id_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req0 = 1'b1; req1 = 1'b1;
        rst = 1'b1;
        tick(); tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", gnt0, gnt1); end
        checks++; if (shf_d !== 8'h00) begin errors++; $display("FAIL reset_shf_d: got %h want 00", shf_d); end
        checks++; if (shf_n !== 8'h01) begin errors++; $display("FAIL reset_shf_n: got %b want 00000001", shf_n); end
        checks++; if (res !== 8'h00) begin errors++; $display("FAIL reset_res: got %h want 00", res); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id: got %b want 0", res_id); end
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        req0 = 1'b1; d0 = 8'hFF; amt0 = 3'd4;
        tick();
        req0 = 1'b0;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL basic_gnt: got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); end
        checks++; if (shf_n !== 8'b0001_0000) begin errors++; $display("FAIL basic_shf_n: got %b want 00010000", shf_n); end
        checks++; if (shf_d !== 8'hFF) begin errors++; $display("FAIL basic_shf_d: got %h want ff", shf_d); end
        tick();
        checks++; if (gnt0 !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL basic_mid: got gnt0=%b res_valid=%b want 0 0", gnt0, res_valid); end
        checks++; if (shf_n !== 8'b0001_0000 || shf_d !== 8'hFF) begin errors++; $display("FAIL basic_stable: got d=%h n=%b want ff 00010000", shf_d, shf_n); end
        tick();
        checks++; if (res_valid !== 1'b1 || res !== 8'hF0 || res_id !== 1'b0) begin errors++; $display("FAIL basic_res: got v=%b res=%h id=%b want 1 f0 0", res_valid, res, res_id); end
        tick();
        checks++; if (res_valid !== 1'b0 || res !== 8'hF0) begin errors++; $display("FAIL basic_hold: got v=%b res=%h want 0 f0", res_valid, res); end
    endtask

    task automatic test_back_to_back();
        int cyc, prev_g, g1cnt, lat, exp_id;
        logic found;
        logic [7:0] exp_res;
        do_reset();
        req0 = 1'b1; d0 = 8'h58; amt0 = 3'd1;
        req1 = 1'b1; d1 = 8'h01; amt1 = 3'd7;
        cyc = 0; prev_g = 0; g1cnt = 0;
        for (int op = 0; op < 4; op++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = op % 2;
`endif
            exp_res = (exp_id == 1) ? 8'h80 : 8'hB0;
            found = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                tick(); cyc++;
                if (gnt0 || gnt1) found = 1'b1;
            end
            if (gnt1) g1cnt++;
            checks++;
            if (!found) begin errors++; $display("FAIL b2b_gnt_timeout: op %0d got no grant want grant", op); end
            else if (gnt1 !== exp_id[0] || gnt0 !== !exp_id[0]) begin
                errors++; $display("FAIL b2b_order: op %0d got gnt0=%b gnt1=%b want id %0d", op, gnt0, gnt1, exp_id);
            end
            if (op > 0) begin
                checks++; if (cyc - prev_g != 3) begin errors++; $display("FAIL b2b_spacing: op %0d got %0d cycles want 3", op, cyc - prev_g); end
            end
            prev_g = cyc;
            found = 1'b0; lat = 0;
            for (int c = 0; c < 10 && !found; c++) begin
                tick(); cyc++; lat++;
                if (gnt1) g1cnt++;
                if (res_valid) found = 1'b1;
            end
            checks++; if (!found || lat != 2) begin errors++; $display("FAIL b2b_latency: op %0d got %0d cycles want 2", op, lat); end
            checks++; if (res !== exp_res || res_id !== exp_id[0]) begin errors++; $display("FAIL b2b_res: op %0d got %h id %b want %h id %0d", op, res, res_id, exp_res, exp_id); end
        end
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        checks++; if (g1cnt != 0) begin errors++; $display("FAIL b2b_gnt1_count: got %0d want 0", g1cnt); end
`else
        checks++; if (g1cnt != 2) begin errors++; $display("FAIL b2b_gnt1_count: got %0d want 2", g1cnt); end
`endif
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_settle4();
        int busy_gnts;
        do_reset();
        req1_b = 1'b1; d1_b = 8'h58; amt1_b = 3'd0;
        tick();
        checks++; if (gnt1_b !== 1'b1 || shf_n_b !== 8'h01) begin errors++; $display("FAIL s4_gnt: got gnt1=%b n=%b want 1 00000001", gnt1_b, shf_n_b); end
        busy_gnts = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (gnt0_b || gnt1_b) busy_gnts++;
            if (k < 5) begin
                checks++; if (res_valid_b !== 1'b0) begin errors++; $display("FAIL s4_early_valid: cycle %0d got 1 want 0", k); end
            end
        end
        checks++; if (res_valid_b !== 1'b1 || res_b !== 8'h58 || res_id_b !== 1'b1) begin errors++; $display("FAIL s4_res: got v=%b res=%h id=%b want 1 58 1", res_valid_b, res_b, res_id_b); end
        checks++; if (busy_gnts != 0) begin errors++; $display("FAIL s4_busy_gnt: got %0d want 0", busy_gnts); end
        req1_b = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int vcnt;
        do_reset();
        req0 = 1'b1; d0 = 8'h3C; amt0 = 3'd2;
        tick();
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", gnt0); end
        rst = 1'b1; req1 = 1'b1;
        tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL rmid_dominate: got gnt=%b%b v=%b want 000", gnt0, gnt1, res_valid); end
        checks++; if (shf_d !== 8'h00 || shf_n !== 8'h01 || res !== 8'h00 || res_id !== 1'b0) begin errors++; $display("FAIL rmid_values: got d=%h n=%b res=%h id=%b want 00 00000001 00 0", shf_d, shf_n, res, res_id); end
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (res_valid) vcnt++;
        end
        checks++; if (vcnt != 0) begin errors++; $display("FAIL rmid_no_valid: got %0d pulses want 0", vcnt); end
        req0 = 1'b1; req1 = 1'b1;
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL rmid_tie: got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_amt_sweep();
        logic [7:0] exp_n;
        do_reset();
        for (int a = 0; a < 8; a++) begin
            exp_n = 8'd1 << a;
            req0 = 1'b1; d0 = 8'h01; amt0 = 3'(a);
            tick();
            req0 = 1'b0;
            checks++; if (gnt0 !== 1'b1 || shf_n !== exp_n) begin errors++; $display("FAIL sweep_shf_n: amt %0d got gnt0=%b n=%b want 1 %b", a, gnt0, shf_n, exp_n); end
            tick(); tick();
            checks++; if (res_valid !== 1'b1 || res !== exp_n) begin errors++; $display("FAIL sweep_res: amt %0d got v=%b res=%b want 1 %b", a, res_valid, res, exp_n); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_settle4();
        test_reset_mid();
        test_amt_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
